// File: rtl/button_debouncer.sv
// Per-bit synchroniser plus stability-counter debouncer with rise/fall strobes.
// Press events are queued by button index and handed out one at a time on a valid/ready port.
module button_debouncer #(
  parameter int SIZE          = 4,
  parameter int STABLE_CYCLES = 16,
  parameter int IDX_W         = (SIZE > 1) ? $clog2(SIZE) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SIZE-1:0]  raw,
  output logic [SIZE-1:0]  level,
  output logic [SIZE-1:0]  rise,
  output logic [SIZE-1:0]  fall,
  output logic             evt_valid,
  output logic [IDX_W-1:0] evt_code,
  input  logic             evt_ready,
  output logic             evt_overrun
);

  localparam int CNT_W = $clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_STABLE_LO = 2'd0,
    ST_PEND_HI   = 2'd1,
    ST_STABLE_HI = 2'd2,
    ST_PEND_LO   = 2'd3
  } state_t;

  logic [SIZE-1:0]  r_s1;
  logic [SIZE-1:0]  r_s2;
  state_t           r_state [SIZE];
  logic [CNT_W-1:0] r_cnt   [SIZE];
  logic [SIZE-1:0]  r_level;
  logic [SIZE-1:0]  r_rise;
  logic [SIZE-1:0]  r_fall;
  logic [SIZE-1:0]  r_pending;
  logic             r_evt_valid;
  logic [IDX_W-1:0] r_evt_code;
  logic             r_evt_overrun;

  logic             w_load;
  logic [SIZE-1:0]  w_lowest;
  logic [SIZE-1:0]  w_clr;
  logic [IDX_W-1:0] w_sel_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= raw;
      r_s2 <= r_s1;
    end
  end

  // A level flips only after STABLE_CYCLES consecutive mismatching synchronised samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SIZE; i++) begin
        r_state[i] <= ST_STABLE_LO;
        r_cnt[i]   <= '0;
      end
      r_level <= '0;
      r_rise  <= '0;
      r_fall  <= '0;
    end else begin
      r_rise <= '0;
      r_fall <= '0;
      for (int i = 0; i < SIZE; i++) begin
        case (r_state[i])
          ST_STABLE_LO, ST_STABLE_HI: begin
            if (r_s2[i] != r_level[i]) begin
              r_state[i] <= r_level[i] ? ST_PEND_LO : ST_PEND_HI;
              r_cnt[i]   <= CNT_W'(1);
            end else begin
              r_cnt[i] <= '0;
            end
          end
          ST_PEND_HI, ST_PEND_LO: begin
            if (r_s2[i] == r_level[i]) begin
              r_state[i] <= r_level[i] ? ST_STABLE_HI : ST_STABLE_LO;
              r_cnt[i]   <= '0;
            end else if (r_cnt[i] == C_LAST) begin
              r_state[i] <= r_level[i] ? ST_STABLE_LO : ST_STABLE_HI;
              r_cnt[i]   <= '0;
              r_level[i] <= ~r_level[i];
              r_rise[i]  <= ~r_level[i];
              r_fall[i]  <= r_level[i];
            end else begin
              r_cnt[i] <= r_cnt[i] + CNT_W'(1);
            end
          end
          default: begin
            r_state[i] <= ST_STABLE_LO;
            r_cnt[i]   <= '0;
          end
        endcase
      end
    end
  end

  // Event port: a transfer happens on an edge where evt_valid && evt_ready; the
  // producer holds evt_code steady while evt_valid is high and evt_ready is low.
  always_comb begin
    w_load   = !r_evt_valid || evt_ready;
    w_lowest = r_pending & (~r_pending + SIZE'(1));
    w_clr    = w_load ? w_lowest : '0;
    w_sel_idx = '0;
    for (int i = SIZE - 1; i >= 0; i--) begin
      if (r_pending[i]) w_sel_idx = IDX_W'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending     <= '0;
      r_evt_valid   <= 1'b0;
      r_evt_code    <= '0;
      r_evt_overrun <= 1'b0;
    end else begin
      // A rise on a bit being loaded this edge re-arms it rather than overrunning.
      r_pending     <= (r_pending & ~w_clr) | r_rise;
      r_evt_overrun <= |(r_rise & r_pending & ~w_clr);
      if (w_load) begin
        r_evt_valid <= |r_pending;
        if (|r_pending) r_evt_code <= w_sel_idx;
      end
    end
  end

  assign level       = r_level;
  assign rise        = r_rise;
  assign fall        = r_fall;
  assign evt_valid   = r_evt_valid;
  assign evt_code    = r_evt_code;
  assign evt_overrun = r_evt_overrun;

endmodule

// File: doc/button_debouncer.md
Name: button_debouncer

Overview:
- Sits directly downstream of the pin pull-down/sampling stage, which delivers `SIZE` sampled button/switch levels (idle low).
- Synchronises each input and debounces it with a per-bit stability counter.
- Produces clean levels and one-cycle rise/fall strobes per bit.
- Queues press (rise) events into a valid/ready event port for the CPU I/O register.

Parameters:
- SIZE, 4, number of button inputs (≥1).
- STABLE_CYCLES, 16, consecutive cycles a synchronised input must differ from the current level before the level flips (≥2).
- IDX_W, $clog2(SIZE) (min 1), width of the event code.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- raw  input  SIZE  sampled button levels from the pull-down stage; asynchronous to this block's debounce timing.
- level  output  SIZE  debounced level per bit.
- rise  output  SIZE  one-cycle strobe when level[i] goes 0→1.
- fall  output  SIZE  one-cycle strobe when level[i] goes 1→0.
- evt_valid  output  1  press event available.
- evt_code  output  IDX_W  index of the pressed button.
- evt_ready  input  1  consumer accepts the event this cycle.
- evt_overrun  output  1  one-cycle strobe when a press event is dropped.

Behaviour:
- Reset (synchronous):
  - Synchroniser flops, level, counters, rise, fall, pending, evt_valid, evt_code and evt_overrun are all 0.
  - Reset mid-count or mid-handshake discards everything; nothing is emitted in the cycle after reset.
- Synchroniser: 2 flops per bit, raw→s1→s2.
- Per-bit FSM (counter C, width $clog2(STABLE_CYCLES)):
  - States: STABLE_LO, PEND_HI, STABLE_HI, PEND_LO.
  - STABLE_x: if s2 equals level, C stays 0. On mismatch, go to PEND_x with C=1.
  - PEND_x:
    - If s2 equals level again, return to STABLE_x with C=0 (glitch rejected).
    - Else if C==STABLE_CYCLES-1, flip level, pulse rise/fall for one cycle, go to STABLE_ of the new level, C=0.
    - Otherwise C increments.
  - Latency: raw steady from before edge k → level and strobe visible after edge k+STABLE_CYCLES+1, i.e. STABLE_CYCLES+2 edges including edge k.
  - Inputs pulsing shorter than STABLE_CYCLES synchronised cycles never change level.
  - rise/fall are registered, one cycle wide, and coincide with the first cycle of the new level.
  - A button held through reset is reported as a rise once the counter completes.
- Event queue:
  - pending[SIZE] register; rise[i] sets pending[i] at the clock edge ending the rise cycle.
  - Output register (evt_valid, evt_code) loads when empty (!evt_valid) or when accepted (evt_valid && evt_ready):
    - Takes the lowest-index set pending bit and clears that bit in the same edge.
    - If no pending bits are set, evt_valid←0.
  - Earliest evt_valid is 2 cycles after the rise strobe cycle.
  - evt_code is stable while evt_valid && !evt_ready, even if lower-index presses arrive.
  - Overrun: if rise[i] occurs while pending[i] is already set and pending[i] is not being cleared by a load on that edge:
    - pending[i] stays 1.
    - evt_overrun pulses for one cycle (registered).
  - A rise on the index currently held in the output register is not an overrun; it sets pending.
  - Simultaneous rise and load-clear on the same bit: pending[i] ends at 1, no overrun.
  - Multiple simultaneous rises set multiple pending bits; they drain lowest-first, one per accepted transfer.
  - Back-to-back transfers with evt_ready held high: one event per cycle while pending is non-empty.
- fall never generates events.

Test Plan (SIZE=4, STABLE_CYCLES=4):
- Press: raw[0] 0→1 held, evt_ready=1 → level[0]=1 and rise[0]=1 exactly 6 edges later (rise for 1 cycle); evt_valid=1, evt_code=0 for one cycle 2 cycles after rise; release → fall[0] 6 edges after release, no event.
- Glitch: raw[1] high for 3 cycles, then low → level, rise and evt_valid stay 0 throughout.
- Bounce: raw[2] toggles every 2 cycles for 12 cycles, then steady 1 → exactly one rise[2] pulse, 6 edges after the last toggle; exactly one event, code 2.
- Backpressure/priority: evt_ready=0; press bit 2, then bits 1 and 3 simultaneously; after all rises, set evt_ready=1 → codes delivered 2, 1, 3 on consecutive cycles; evt_code held at 2 while stalled; evt_overrun never asserts.
- Overrun: evt_ready=0; press/release bit 0 three times → first press in output register, second in pending, third pulses evt_overrun once; drain yields code 0 exactly twice.
- Reset mid-operation: assert rst while bit 3 is in PEND_HI with an event pending → next cycle all outputs 0, evt_valid=0; raw[3] still high after release of rst → rise[3] 6 edges later, one event, code 3.
